// File: rtl/motion_centroid_tracker_if.sv
// Pixel-stream / result bundle for motion_centroid_tracker.
//   master : pixel source and result consumer (compare stage + overlay side)
//   slave  : the tracker itself
// Signals:
//   DE, x_pixel, y_pixel, motion_flag  -- per-pixel stream, sampled every clk
//   com_x, com_y                       -- centroid of last valid frame
//   bbox_x_min/max, bbox_y_min/max     -- bounding box (0 when below threshold)
//   motion_count, motion_present       -- motion pixel count / threshold flag
//   frame_done, busy, overrun          -- status
interface motion_centroid_tracker_if #(
  parameter int COORD_W = 10,
  parameter int CNT_W   = 17
);
  logic               DE;
  logic [COORD_W-1:0] x_pixel;
  logic [COORD_W-1:0] y_pixel;
  logic               motion_flag;

  logic [COORD_W-1:0] com_x;
  logic [COORD_W-1:0] com_y;
  logic [COORD_W-1:0] bbox_x_min;
  logic [COORD_W-1:0] bbox_x_max;
  logic [COORD_W-1:0] bbox_y_min;
  logic [COORD_W-1:0] bbox_y_max;
  logic [CNT_W-1:0]   motion_count;
  logic               motion_present;
  logic               frame_done;
  logic               busy;
  logic               overrun;

  modport master (
    output DE, x_pixel, y_pixel, motion_flag,
    input  com_x, com_y, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
    input  motion_count, motion_present, frame_done, busy, overrun
  );

  modport slave (
    input  DE, x_pixel, y_pixel, motion_flag,
    output com_x, com_y, bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max,
    output motion_count, motion_present, frame_done, busy, overrun
  );
endinterface

// File: rtl/motion_centroid_tracker.sv
// Frame-level motion centroid tracker.
// Accumulates coordinates of motion pixels inside the H_ACT x V_ACT window,
// snapshots them at the last active pixel, and divides sum/count with a
// restoring divider (x and y in parallel). Results update atomically with a
// one-cycle frame_done pulse, SUM_W+1 cycles after the last active pixel.
// Ports:
//   clk      -- pixel clock
//   reset_n  -- asynchronous active-low reset
//   bus      -- slave side of motion_centroid_tracker_if (pixel in, results out)
module motion_centroid_tracker #(
  parameter int H_ACT     = 320,
  parameter int V_ACT     = 240,
  parameter int COORD_W   = 10,
  parameter int MIN_COUNT = 4
) (
  input logic                      clk,
  input logic                      reset_n,
  motion_centroid_tracker_if.slave bus
);
  localparam int CNT_W  = $clog2(H_ACT*V_ACT+1);
  localparam int SUM_W  = $clog2(H_ACT*V_ACT) + COORD_W;
  localparam int ITER_W = $clog2(SUM_W);
  localparam logic [COORD_W-1:0] MIN_INIT = '1;
  localparam logic [COORD_W-1:0] MAX_INIT = '0;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t state, state_nxt;

  // Running accumulators and their values including the current pixel.
  logic [SUM_W-1:0]   acc_sx, acc_sy, nxt_sx, nxt_sy;
  logic [CNT_W-1:0]   acc_cnt, nxt_cnt;
  logic [COORD_W-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [COORD_W-1:0] nxt_xmin, nxt_xmax, nxt_ymin, nxt_ymax;

  // Snapshot; dvd_x/dvd_y start as the sums and shift into the quotients.
  logic [SUM_W-1:0]   dvd_x, dvd_y;
  logic [CNT_W-1:0]   snap_cnt;
  logic [COORD_W-1:0] snap_xmin, snap_xmax, snap_ymin, snap_ymax;
  logic [CNT_W-1:0]   rem_x, rem_y;
  logic [ITER_W-1:0]  iter;

  // Divider step signals.
  logic [CNT_W:0]     trial_x, trial_y, diff_x, diff_y;
  logic               q_x, q_y;
  logic [CNT_W-1:0]   rem_x_nxt, rem_y_nxt;
  logic [SUM_W-1:0]   dvd_x_nxt, dvd_y_nxt;

  // Output registers.
  logic [COORD_W-1:0] com_x_q, com_y_q;
  logic [COORD_W-1:0] bx_min_q, bx_max_q, by_min_q, by_max_q;
  logic [CNT_W-1:0]   count_q;
  logic               present_q, overrun_q;

  logic accept, hit, frame_end, last_iter, snap_load, load_out;

  assign accept    = bus.DE && (bus.x_pixel < COORD_W'(H_ACT)) && (bus.y_pixel < COORD_W'(V_ACT));
  assign hit       = accept && bus.motion_flag;
  assign frame_end = accept && (bus.x_pixel == COORD_W'(H_ACT-1)) && (bus.y_pixel == COORD_W'(V_ACT-1));
  assign last_iter = (iter == ITER_W'(SUM_W-1));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    nxt_sx   = acc_sx;
    nxt_sy   = acc_sy;
    nxt_cnt  = acc_cnt;
    nxt_xmin = acc_xmin;
    nxt_xmax = acc_xmax;
    nxt_ymin = acc_ymin;
    nxt_ymax = acc_ymax;
    if (hit) begin
      nxt_sx  = acc_sx + SUM_W'(bus.x_pixel);
      nxt_sy  = acc_sy + SUM_W'(bus.y_pixel);
      nxt_cnt = acc_cnt + CNT_W'(1);
      if (bus.x_pixel < acc_xmin) nxt_xmin = bus.x_pixel;
      if (bus.x_pixel > acc_xmax) nxt_xmax = bus.x_pixel;
      if (bus.y_pixel < acc_ymin) nxt_ymin = bus.y_pixel;
      if (bus.y_pixel > acc_ymax) nxt_ymax = bus.y_pixel;
    end
  end

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the count when it fits. The remainder stays below the divisor,
  // so CNT_W bits hold it; with cnt = 0 the result is garbage but unused.
  always_comb begin
    trial_x   = {rem_x, dvd_x[SUM_W-1]};
    trial_y   = {rem_y, dvd_y[SUM_W-1]};
    diff_x    = trial_x - {1'b0, snap_cnt};
    diff_y    = trial_y - {1'b0, snap_cnt};
    q_x       = (trial_x >= {1'b0, snap_cnt});
    q_y       = (trial_y >= {1'b0, snap_cnt});
    rem_x_nxt = q_x ? diff_x[CNT_W-1:0] : trial_x[CNT_W-1:0];
    rem_y_nxt = q_y ? diff_y[CNT_W-1:0] : trial_y[CNT_W-1:0];
    dvd_x_nxt = {dvd_x[SUM_W-2:0], q_x};
    dvd_y_nxt = {dvd_y[SUM_W-2:0], q_y};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Outputs are loaded on the edge that leaves the last DIV cycle, so they
  // are already valid during the DONE cycle in which frame_done is high.
  always_comb begin
    state_nxt = state;
    snap_load = 1'b0;
    load_out  = 1'b0;
    case (state)
      IDLE: if (frame_end) begin
        snap_load = 1'b1;
        state_nxt = DIV;
      end
      DIV: if (last_iter) begin
        load_out  = 1'b1;
        state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
      acc_sx    <= '0;
      acc_sy    <= '0;
      acc_cnt   <= '0;
      acc_xmin  <= MIN_INIT;
      acc_xmax  <= MAX_INIT;
      acc_ymin  <= MIN_INIT;
      acc_ymax  <= MAX_INIT;
      dvd_x     <= '0;
      dvd_y     <= '0;
      snap_cnt  <= '0;
      snap_xmin <= '0;
      snap_xmax <= '0;
      snap_ymin <= '0;
      snap_ymax <= '0;
      rem_x     <= '0;
      rem_y     <= '0;
      iter      <= '0;
      com_x_q   <= '0;
      com_y_q   <= '0;
      bx_min_q  <= '0;
      bx_max_q  <= '0;
      by_min_q  <= '0;
      by_max_q  <= '0;
      count_q   <= '0;
      present_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      // The frame-end pixel itself is folded in via the nxt_* values, and
      // the accumulators clear even when the frame is dropped for overrun.
      if (frame_end) begin
        acc_sx   <= '0;
        acc_sy   <= '0;
        acc_cnt  <= '0;
        acc_xmin <= MIN_INIT;
        acc_xmax <= MAX_INIT;
        acc_ymin <= MIN_INIT;
        acc_ymax <= MAX_INIT;
      end else begin
        acc_sx   <= nxt_sx;
        acc_sy   <= nxt_sy;
        acc_cnt  <= nxt_cnt;
        acc_xmin <= nxt_xmin;
        acc_xmax <= nxt_xmax;
        acc_ymin <= nxt_ymin;
        acc_ymax <= nxt_ymax;
      end

      if (frame_end && state != IDLE) overrun_q <= 1'b1;

      if (snap_load) begin
        dvd_x     <= nxt_sx;
        dvd_y     <= nxt_sy;
        snap_cnt  <= nxt_cnt;
        snap_xmin <= nxt_xmin;
        snap_xmax <= nxt_xmax;
        snap_ymin <= nxt_ymin;
        snap_ymax <= nxt_ymax;
        rem_x     <= '0;
        rem_y     <= '0;
        iter      <= '0;
      end else if (state == DIV) begin
        dvd_x <= dvd_x_nxt;
        dvd_y <= dvd_y_nxt;
        rem_x <= rem_x_nxt;
        rem_y <= rem_y_nxt;
        iter  <= iter + ITER_W'(1);
      end

      if (load_out) begin
        count_q <= snap_cnt;
        if (snap_cnt >= CNT_W'(MIN_COUNT)) begin
          com_x_q   <= dvd_x_nxt[COORD_W-1:0];
          com_y_q   <= dvd_y_nxt[COORD_W-1:0];
          bx_min_q  <= snap_xmin;
          bx_max_q  <= snap_xmax;
          by_min_q  <= snap_ymin;
          by_max_q  <= snap_ymax;
          present_q <= 1'b1;
        end else begin
          bx_min_q  <= '0;
          bx_max_q  <= '0;
          by_min_q  <= '0;
          by_max_q  <= '0;
          present_q <= 1'b0;
        end
      end
    end
  end

  assign bus.com_x          = com_x_q;
  assign bus.com_y          = com_y_q;
  assign bus.bbox_x_min     = bx_min_q;
  assign bus.bbox_x_max     = bx_max_q;
  assign bus.bbox_y_min     = by_min_q;
  assign bus.bbox_y_max     = by_max_q;
  assign bus.motion_count   = count_q;
  assign bus.motion_present = present_q;
  assign bus.overrun        = overrun_q;
  assign bus.busy           = (state == DIV);
  assign bus.frame_done     = (state == DONE);
endmodule

// File: tb/tb_motion_centroid_tracker.sv
// Directed self-checking bench for motion_centroid_tracker (default parameters).
// Only the pixels that matter are presented; the frame end is pixel (319,239).
module tb_motion_centroid_tracker;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  motion_centroid_tracker_if #(.COORD_W(10), .CNT_W(17)) bus ();

  motion_centroid_tracker dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Present one pixel for exactly one clock edge, then return the stream to idle.
  task automatic drive_px(input logic de, input int x, input int y, input logic m);
    bus.DE          = de;
    bus.x_pixel     = 10'(x);
    bus.y_pixel     = 10'(y);
    bus.motion_flag = m;
    @(posedge clk);
    #1;
    bus.DE          = 1'b0;
    bus.motion_flag = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_px(1'b0, 0, 0, 1'b0);
  endtask

  // Count clock edges until frame_done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (bus.frame_done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    bus.DE = 1'b0; bus.x_pixel = '0; bus.y_pixel = '0; bus.motion_flag = 1'b0;
    reset_n = 1'b0;
    #12;
    n_total++;
    if ({bus.com_x, bus.com_y, bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max} !== 60'd0)
      $display("FAIL reset coords: got %h want 0", {bus.com_x, bus.com_y, bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max});
    else n_pass++;
    n_total++;
    if ({bus.motion_count, bus.motion_present, bus.frame_done, bus.busy, bus.overrun} !== 21'd0)
      $display("FAIL reset status: got %h want 0", {bus.motion_count, bus.motion_present, bus.frame_done, bus.busy, bus.overrun});
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_block_2x2;
    int n;
    drive_px(1'b1, 100, 50, 1'b1);
    drive_px(1'b1, 101, 50, 1'b1);
    drive_px(1'b1, 100, 51, 1'b1);
    drive_px(1'b1, 101, 51, 1'b1);
    idle(3);
    drive_px(1'b1, 319, 239, 1'b0);
    n_total++;
    if (bus.busy !== 1'b1) $display("FAIL 2x2 busy at T+1: got %b want 1", bus.busy);
    else n_pass++;
    wait_done(n);
    n_total++;
    if (n + 1 != 28) $display("FAIL 2x2 latency: got %0d want 28", n + 1);
    else n_pass++;
    n_total++;
    if (bus.motion_count !== 17'd4 || bus.motion_present !== 1'b1)
      $display("FAIL 2x2 count: got %0d/%b want 4/1", bus.motion_count, bus.motion_present);
    else n_pass++;
    n_total++;
    if (bus.com_x !== 10'd100 || bus.com_y !== 10'd50)
      $display("FAIL 2x2 com: got (%0d,%0d) want (100,50)", bus.com_x, bus.com_y);
    else n_pass++;
    n_total++;
    if ({bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max} !== {10'd100, 10'd101, 10'd50, 10'd51})
      $display("FAIL 2x2 bbox: got %0d/%0d/%0d/%0d want 100/101/50/51", bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL 2x2 pulse width: got done=%b busy=%b want 0/0", bus.frame_done, bus.busy);
    else n_pass++;
  endtask

  task automatic test_below_threshold;
    int n;
    drive_px(1'b1, 10, 10, 1'b1);
    drive_px(1'b1, 11, 10, 1'b1);
    drive_px(1'b1, 12, 10, 1'b1);
    drive_px(1'b1, 319, 239, 1'b0);
    wait_done(n);
    n_total++;
    if (n != 27) $display("FAIL below done: got %0d edges want 27", n);
    else n_pass++;
    n_total++;
    if (bus.motion_count !== 17'd3 || bus.motion_present !== 1'b0)
      $display("FAIL below count: got %0d/%b want 3/0", bus.motion_count, bus.motion_present);
    else n_pass++;
    n_total++;
    if (bus.com_x !== 10'd100 || bus.com_y !== 10'd50)
      $display("FAIL below com hold: got (%0d,%0d) want (100,50)", bus.com_x, bus.com_y);
    else n_pass++;
    n_total++;
    if ({bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max} !== 40'd0)
      $display("FAIL below bbox: got %0d/%0d/%0d/%0d want 0/0/0/0", bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max);
    else n_pass++;
  endtask

  // Window corners, including a flagged frame-end pixel that must be counted.
  task automatic test_extremes;
    int n;
    drive_px(1'b1, 0, 0, 1'b1);
    drive_px(1'b1, 319, 0, 1'b1);
    drive_px(1'b1, 0, 239, 1'b1);
    drive_px(1'b1, 319, 239, 1'b1);
    wait_done(n);
    n_total++;
    if (bus.motion_count !== 17'd4 || bus.motion_present !== 1'b1)
      $display("FAIL extremes count: got %0d/%b want 4/1", bus.motion_count, bus.motion_present);
    else n_pass++;
    n_total++;
    if (bus.com_x !== 10'd159 || bus.com_y !== 10'd119)
      $display("FAIL extremes com: got (%0d,%0d) want (159,119)", bus.com_x, bus.com_y);
    else n_pass++;
    n_total++;
    if ({bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max} !== {10'd0, 10'd319, 10'd0, 10'd239})
      $display("FAIL extremes bbox: got %0d/%0d/%0d/%0d want 0/319/0/239", bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max);
    else n_pass++;
  endtask

  task automatic test_out_of_window;
    int n;
    drive_px(1'b1, 320, 5, 1'b1);
    drive_px(1'b1, 1023, 100, 1'b1);
    drive_px(1'b1, 5, 240, 1'b1);
    drive_px(1'b1, 319, 1023, 1'b1);
    drive_px(1'b0, 50, 50, 1'b1);
    drive_px(1'b0, 319, 239, 1'b1);
    drive_px(1'b1, 319, 239, 1'b0);
    wait_done(n);
    n_total++;
    if (n != 27) $display("FAIL oow done: got %0d edges want 27", n);
    else n_pass++;
    n_total++;
    if (bus.motion_count !== 17'd0 || bus.motion_present !== 1'b0)
      $display("FAIL oow count: got %0d/%b want 0/0", bus.motion_count, bus.motion_present);
    else n_pass++;
    n_total++;
    if (bus.com_x !== 10'd159 || bus.com_y !== 10'd119)
      $display("FAIL oow com hold: got (%0d,%0d) want (159,119)", bus.com_x, bus.com_y);
    else n_pass++;
  endtask

  task automatic test_overrun;
    int n;
    drive_px(1'b1, 20, 30, 1'b1);
    drive_px(1'b1, 21, 30, 1'b1);
    drive_px(1'b1, 22, 30, 1'b1);
    drive_px(1'b1, 23, 31, 1'b1);
    drive_px(1'b1, 319, 239, 1'b0);
    idle(4);
    n_total++;
    if (bus.overrun !== 1'b0) $display("FAIL overrun early: got %b want 0", bus.overrun);
    else n_pass++;
    drive_px(1'b1, 319, 239, 1'b1);
    n_total++;
    if (bus.overrun !== 1'b1 || bus.busy !== 1'b1)
      $display("FAIL overrun set: got ovr=%b busy=%b want 1/1", bus.overrun, bus.busy);
    else n_pass++;
    n_total++;
    if (bus.com_x !== 10'd159 || bus.motion_count !== 17'd0)
      $display("FAIL overrun stable: got com_x=%0d cnt=%0d want 159/0", bus.com_x, bus.motion_count);
    else n_pass++;
    wait_done(n);
    n_total++;
    if (n != 22) $display("FAIL overrun latency: got %0d edges want 22", n);
    else n_pass++;
    n_total++;
    if (bus.com_x !== 10'd21 || bus.com_y !== 10'd30 || bus.motion_count !== 17'd4)
      $display("FAIL overrun result: got (%0d,%0d) cnt %0d want (21,30) cnt 4", bus.com_x, bus.com_y, bus.motion_count);
    else n_pass++;
    n_total++;
    if ({bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max} !== {10'd20, 10'd23, 10'd30, 10'd31})
      $display("FAIL overrun bbox: got %0d/%0d/%0d/%0d want 20/23/30/31", bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max);
    else n_pass++;
    idle(40);
    n_total++;
    if (bus.motion_count !== 17'd4 || bus.com_x !== 10'd21)
      $display("FAIL overrun dropped: got cnt %0d com_x %0d want 4/21", bus.motion_count, bus.com_x);
    else n_pass++;
    // Next frame must start from cleared accumulators.
    drive_px(1'b1, 40, 40, 1'b1);
    drive_px(1'b1, 42, 44, 1'b1);
    drive_px(1'b1, 44, 48, 1'b1);
    drive_px(1'b1, 46, 52, 1'b1);
    drive_px(1'b1, 319, 239, 1'b0);
    wait_done(n);
    n_total++;
    if (bus.motion_count !== 17'd4 || bus.com_x !== 10'd43 || bus.com_y !== 10'd46)
      $display("FAIL post-overrun: got cnt %0d com (%0d,%0d) want 4 (43,46)", bus.motion_count, bus.com_x, bus.com_y);
    else n_pass++;
    n_total++;
    if ({bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max, bus.overrun} !== {10'd40, 10'd46, 10'd40, 10'd52, 1'b1})
      $display("FAIL post-overrun bbox/ovr: got %0d/%0d/%0d/%0d ovr %b want 40/46/40/52 ovr 1", bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max, bus.overrun);
    else n_pass++;
  endtask

  task automatic test_reset_mid_div;
    int  n;
    bit  seen;
    drive_px(1'b1, 100, 50, 1'b1);
    drive_px(1'b1, 101, 51, 1'b1);
    drive_px(1'b1, 102, 52, 1'b1);
    drive_px(1'b1, 103, 53, 1'b1);
    drive_px(1'b1, 319, 239, 1'b0);
    idle(10);
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({bus.com_x, bus.com_y, bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max} !== 60'd0)
      $display("FAIL mid-div reset coords: got %h want 0", {bus.com_x, bus.com_y, bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max});
    else n_pass++;
    n_total++;
    if ({bus.motion_count, bus.motion_present, bus.frame_done, bus.busy, bus.overrun} !== 21'd0)
      $display("FAIL mid-div reset status: got %h want 0", {bus.motion_count, bus.motion_present, bus.frame_done, bus.busy, bus.overrun});
    else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_done === 1'b1) seen = 1'b1;
    end
    n_total++;
    if (seen) $display("FAIL mid-div aborted: got frame_done=1 want no pulse");
    else n_pass++;
    drive_px(1'b1, 7, 9, 1'b1);
    drive_px(1'b1, 8, 9, 1'b1);
    drive_px(1'b1, 9, 9, 1'b1);
    drive_px(1'b1, 10, 9, 1'b1);
    drive_px(1'b1, 11, 13, 1'b1);
    drive_px(1'b1, 319, 239, 1'b0);
    wait_done(n);
    n_total++;
    if (n != 27) $display("FAIL after reset done: got %0d edges want 27", n);
    else n_pass++;
    n_total++;
    if (bus.motion_count !== 17'd5 || bus.com_x !== 10'd9 || bus.com_y !== 10'd9 || bus.motion_present !== 1'b1)
      $display("FAIL after reset result: got cnt %0d com (%0d,%0d) pres %b want 5 (9,9) 1", bus.motion_count, bus.com_x, bus.com_y, bus.motion_present);
    else n_pass++;
    n_total++;
    if ({bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max} !== {10'd7, 10'd11, 10'd9, 10'd13})
      $display("FAIL after reset bbox: got %0d/%0d/%0d/%0d want 7/11/9/13", bus.bbox_x_min, bus.bbox_x_max, bus.bbox_y_min, bus.bbox_y_max);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_block_2x2();
    test_below_threshold();
    test_extremes();
    test_out_of_window();
    test_overrun();
    test_reset_mid_div();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/motion_centroid_tracker.md
# motion_centroid_tracker

Parametrised successor to the frame-level motion centre-of-mass block. It sits between the pixel compare stage (`motion_flag`) and the display overlay. It accumulates motion-pixel coordinates over a configurable active window and computes the centroid with a sequential divider, replacing the combinational divide. It also reports motion pixel count, bounding box and a presence threshold, and outputs update atomically once per frame.

## Interface
- `H_ACT`, 320, active window width in pixels; pixels with `x_pixel >= H_ACT` are ignored.
- `V_ACT`, 240, active window height in lines.
- `COORD_W`, 10, width of `x_pixel`, `y_pixel` and all coordinate outputs.
- `MIN_COUNT`, 4, minimum motion pixels per frame for a valid detection.
- Derived parameters:
  - `CNT_W` = $clog2(H_ACT*V_ACT+1)
  - `SUM_W` = $clog2(H_ACT*V_ACT) + COORD_W
- `clk`, in, 1, pixel clock. The block has one clock.
- `reset_n`, in, 1, asynchronous, active-low reset.
- `DE`, in, 1, VGA data enable.
- `x_pixel`, in, COORD_W, current pixel column.
- `y_pixel`, in, COORD_W, current pixel row.
- `motion_flag`, in, 1, motion detected at the current pixel.
- `com_x`, out, COORD_W, centroid column.
- `com_y`, out, COORD_W, centroid row.
- `bbox_x_min`, out, COORD_W, bounding-box left edge.
- `bbox_x_max`, out, COORD_W, bounding-box right edge.
- `bbox_y_min`, out, COORD_W, bounding-box top edge.
- `bbox_y_max`, out, COORD_W, bounding-box bottom edge.
- `motion_count`, out, CNT_W, motion pixels in the last completed frame.
- `motion_present`, out, 1, `motion_count >= MIN_COUNT`.
- `frame_done`, out, 1, one-cycle pulse when outputs update.
- `busy`, out, 1, divider running.
- `overrun`, out, 1, sticky flag: a frame end occurred while `busy`.

## Operation
- **Accept condition:** `DE & (x_pixel < H_ACT) & (y_pixel < V_ACT)`.
- **Per accepted pixel with `motion_flag = 1`:**
  - `sum_x += x_pixel`, `sum_y += y_pixel`, `cnt += 1`.
  - `xmin`/`xmax`/`ymin`/`ymax` are updated with min/max. Running min registers initialise to all-ones and max registers to 0.
- **Frame end:** the accepted pixel at (H_ACT-1, V_ACT-1). It is included in the sums.
  - On that edge, the snapshot registers load `{sum_x, sum_y, cnt, bbox}` including that pixel.
  - The accumulators return to their initial values on the same edge.
  - The next frame accumulates from zero with no lost pixel.
- **FSM:**
  - IDLE → DIV on frame end.
  - DIV runs `SUM_W` iterations, then goes to DONE.
  - DONE updates outputs, pulses `frame_done`, and returns to IDLE in a single cycle.
- **Divider:**
  - Restoring, one quotient bit per cycle for each of x and y in parallel, sharing the divisor `cnt`.
  - Quotient is floor. The low COORD_W bits are taken; the quotient is always < H_ACT or V_ACT.
- **In DONE:**
  - `motion_count` ← snapshot `cnt`.
  - If `cnt >= MIN_COUNT`: update com and bbox, and set `motion_present = 1`.
  - Else: `com_x`/`com_y` hold their previous values, bbox outputs go to 0, and `motion_present = 0`.
  - The `cnt = 0` case takes the else path; divide-by-zero is never used. The divider still runs the full latency.
- **Overrun:**
  - A frame end arriving while not IDLE is discarded; the in-progress division continues.
  - The accumulators still clear.
  - `overrun` is set and stays set until reset.
- **Arithmetic:**
  - Sums are SUM_W bits unsigned and cannot overflow for the window.
  - Comparisons are unsigned.

## Timing
- **Reset (`reset_n = 0`), asynchronous:**
  - All outputs go to 0 and the FSM goes to IDLE.
  - Accumulators and min/max registers go to their initial values.
  - The snapshot is cleared.
  - A reset mid-DIV aborts the division with no `frame_done`.
- **Latency:** let the last active pixel be presented in cycle T.
  - `busy` = 1 from T+1 through T+SUM_W.
  - Outputs change and `frame_done` = 1 in cycle T+SUM_W+1.
  - With defaults, SUM_W = 27, so latency is 28 cycles.
- **Stability:** outputs are stable between `frame_done` pulses. All fields update on the same edge.
- **Input sampling:** `motion_flag` is sampled in the same cycle as `x_pixel`/`y_pixel`, with no input registering.

## Test plan
- **2×2 block:** motion pixels (100,50), (101,50), (100,51), (101,51), defaults.
  - `motion_count = 4`, `com = (100,50)`.
  - bbox = 100/101/50/51, `motion_present = 1`.
  - `frame_done` exactly 28 cycles after pixel (319,239).
- **Below threshold:** next frame has 3 motion pixels at (10,10), (11,10), (12,10).
  - `motion_count = 3`, `motion_present = 0`.
  - com holds (100,50); bbox reads all 0.
- **Full-frame motion:** every active pixel flagged.
  - `motion_count = 76800`, `com = (159,119)` (floor).
  - bbox = 0/319/0/239.
- **Out-of-window:** `motion_flag` driven at x ≥ 320, at y ≥ 240, and with DE = 0.
  - `motion_count = 0`, `motion_present = 0`, `frame_done` still pulses.
- **Reset mid-DIV:** assert `reset_n` low 10 cycles after the frame end.
  - All outputs read 0 immediately; no `frame_done` for that frame.
  - The following frame computes correctly.
- **Overrun:** drive a second (319,239) frame end 5 cycles after the first.
  - `overrun` = 1 and stays set.
  - The first frame's result is delivered at T+28; the second is dropped.
